// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and sizing helper for the digit-serial adder
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells, also exposing the carry into the MSB
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // Ripple the carry LSB to MSB through one full-adder cell per bit.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, DIGIT bits per clock, LSB digit first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: need WIDTH >= 1, 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             d_cmsb;
    logic             last;
    logic             accept;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_sr[DIGIT-1:0]),
        .y     (b_sr[DIGIT-1:0]),
        .cin   (cy),
        .s     (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digit enters at the MSB side; the concat-and-shift form stays legal when DIGIT == WIDTH.
    assign acc_next = WIDTH'({d_sum, acc} >> DIGIT);
    assign last     = cnt == CW'(NDIG - 1);
    assign accept   = start && (state == IDLE || state == DONE);
    assign busy     = state == RUN;
    assign done     = state == DONE;

    // Control FSM, operand shift registers and result publication on the final digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub}};
            cy    <= sub | carry_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            acc  <= acc_next;
            cy   <= d_cout;
            cnt  <= last ? cnt : cnt + 1'b1;
            if (last) begin
                state    <= DONE;
                sum      <= acc_next;
                carry    <= d_cout;
                overflow <= d_cout ^ d_cmsb;
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench over four serial_adder configurations
module tb_serial_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic [3:0]  st = '0;

    wire [3:0]  busy_o, done_o, carry_o, ov_o;
    wire [7:0]  s0, s1, s2;
    wire [15:0] s3;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    logic [15:0] va [5] = '{16'h3C, 16'hFF, 16'h7F, 16'h05, 16'h80};
    logic [15:0] vb [5] = '{16'h0F, 16'h01, 16'h01, 16'h07, 16'h01};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] es [5] = '{16'h4B, 16'h01, 16'h80, 16'hFE, 16'h7F};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin),
        .busy(busy_o[0]), .done(done_o[0]), .sum(s0), .carry(carry_o[0]), .overflow(ov_o[0]));
    serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin),
        .busy(busy_o[1]), .done(done_o[1]), .sum(s1), .carry(carry_o[1]), .overflow(ov_o[1]));
    serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin),
        .busy(busy_o[2]), .done(done_o[2]), .sum(s2), .carry(carry_o[2]), .overflow(ov_o[2]));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sub), .a(a_i), .b(b_i), .carry_in(cin),
        .busy(busy_o[3]), .done(done_o[3]), .sum(s3), .carry(carry_o[3]), .overflow(ov_o[3]));

    function automatic int wof(input int k);
        return (k == 3) ? 16 : 8;
    endfunction

    function automatic int nof(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : (k == 2) ? 1 : 4;
    endfunction

    function automatic logic [15:0] sum_of(input int k);
        return (k == 0) ? {8'h00, s0} : (k == 1) ? {8'h00, s1} : (k == 2) ? {8'h00, s2} : s3;
    endfunction

    // Reference: plain integer add of a and (possibly inverted) b; overflow from operand/result signs.
    function automatic exp_t model(input int k, input logic sb, input logic [15:0] x, input logic [15:0] y, input logic ci);
        int          w;
        logic [16:0] m, xx, yy, f;
        exp_t        e;
        w  = wof(k);
        m  = (17'd1 << w) - 17'd1;
        xx = {1'b0, x} & m;
        yy = sb ? (~{1'b0, y} & m) : ({1'b0, y} & m);
        f  = xx + yy + (sb ? 17'd1 : {16'd0, ci});
        e.s = f[15:0] & m[15:0];
        e.c = f[w];
        e.o = (xx[w-1] == yy[w-1]) && (f[w-1] != xx[w-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic wait_done(input int k, output int lat, output int bc);
        bc  = int'(busy_o[k]);
        lat = 0;
        while (!done_o[k] && lat < nof(k) + 3) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy_o[k]) bc++;
        end
    endtask

    task automatic check_result(input int k);
        exp_t e;
        chk($sformatf("k%0d_sb_nonempty", k), q.size() > 0, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("k%0d_sum", k), sum_of(k), e.s);
            chk($sformatf("k%0d_carry", k), carry_o[k], e.c);
            chk($sformatf("k%0d_overflow", k), ov_o[k], e.o);
        end
    endtask

    task automatic drive(input int k, input logic sb, input logic [15:0] x, input logic [15:0] y, input logic ci);
        sub   = sb;
        a_i   = x;
        b_i   = y;
        cin   = ci;
        st[k] = 1'b1;
        @(posedge clk);
        #1;
        st[k] = 1'b0;
    endtask

    task automatic op(input int k, input logic sb, input logic [15:0] x, input logic [15:0] y, input logic ci, input exp_t e);
        int lat, bc;
        q.push_back(e);
        drive(k, sb, x, y, ci);
        wait_done(k, lat, bc);
        chk($sformatf("k%0d_latency", k), lat, nof(k));
        chk($sformatf("k%0d_busy_cycles", k), bc, nof(k));
        check_result(k);
        @(posedge clk);
        #1;
        chk($sformatf("k%0d_done_pulse", k), done_o[k], 1'b0);
    endtask

    initial begin
        int lat, bc, seen;
        logic [15:0] x, y;
        logic        sb, ci;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d_rst_sum", k), sum_of(k), 16'h0);
            chk($sformatf("k%0d_rst_carry", k), carry_o[k], 1'b0);
            chk($sformatf("k%0d_rst_ovf", k), ov_o[k], 1'b0);
            chk($sformatf("k%0d_rst_busy", k), busy_o[k], 1'b0);
            chk($sformatf("k%0d_rst_done", k), done_o[k], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 5; i++)
                op(k, vs[i], va[i], vb[i], vc[i], exp_t'({es[i], ec[i], eo[i]}));
        op(3, 1'b0, 16'h7FFF, 16'h0001, 1'b0, exp_t'({16'h8000, 1'b0, 1'b1}));
        for (int i = 0; i < 5; i++)
            op(3, vs[i], va[i], vb[i], vc[i], model(3, vs[i], va[i], vb[i], vc[i]));

        // start during RUN must be ignored
        q.push_back(exp_t'({16'h4B, 1'b0, 1'b0}));
        drive(0, 1'b0, 16'h3C, 16'h0F, 1'b0);
        @(posedge clk);
        #1;
        sub = 1'b1; a_i = 16'hAA; b_i = 16'h55; st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        wait_done(0, lat, bc);
        chk("midrun_latency", lat + 2, 4);
        check_result(0);
        @(posedge clk);
        #1;
        chk("midrun_done_pulse", done_o[0], 1'b0);

        // back-to-back restart from DONE
        q.push_back(exp_t'({16'h80, 1'b0, 1'b1}));
        q.push_back(exp_t'({16'hFE, 1'b0, 1'b0}));
        drive(0, 1'b0, 16'h7F, 16'h01, 1'b0);
        wait_done(0, lat, bc);
        chk("b2b_first_latency", lat, 4);
        check_result(0);
        drive(0, 1'b1, 16'h05, 16'h07, 1'b0);
        chk("b2b_busy_after_restart", busy_o[0], 1'b1);
        wait_done(0, lat, bc);
        chk("b2b_second_latency", lat, 4);
        check_result(0);

        // asynchronous reset mid-RUN discards the operation
        drive(0, 1'b0, 16'h11, 16'h22, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", sum_of(0), 16'h0);
        chk("arst_carry", carry_o[0], 1'b0);
        chk("arst_ovf", ov_o[0], 1'b0);
        chk("arst_busy", busy_o[0], 1'b0);
        chk("arst_done", done_o[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done_o[0]) seen++;
        end
        chk("arst_no_done", seen, 0);
        op(0, 1'b0, 16'h3C, 16'h0F, 1'b0, exp_t'({16'h4B, 1'b0, 1'b0}));

        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 1000; i++) begin
                x  = 16'($urandom);
                y  = 16'($urandom);
                sb = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                op(k, sb, x, y, ci, model(k, sb, x, y, ci));
            end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
